// File: rtl/serial_word_tx.sv
// serial_word_tx: parallel-to-serial framer feeding the serial two's-complement stage.
// Accepts a WIDTH-bit word over valid/ready and emits it LSB-first, one bit per clock,
// with back-to-back words streaming without an idle gap.
//
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous active-high reset
//   in_valid  - in_data holds a word to send
//   in_ready  - word can be accepted this cycle (combinational from state)
//   in_data   - parallel word, sampled on in_valid & in_ready
//   ser_bit   - serial data bit, LSB first (registered)
//   ser_start - high on bit 0 of each word; complementer word-start (registered)
//   ser_valid - ser_bit is meaningful (registered)
//   ser_last  - high on bit WIDTH-1 of each word (registered)
module serial_word_tx #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_bit,
    output logic             ser_start,
    output logic             ser_valid,
    output logic             ser_last
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    logic             state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bit_q, bit_d;
    logic             start_q, start_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;

    logic accept;
    logic at_last;

    // cnt_q tracks the index of the bit currently on ser_bit.
    assign at_last  = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
    assign in_ready = !rst && ((state_q == ST_IDLE) || at_last);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        bit_d   = 1'b0;
        start_d = 1'b0;
        valid_d = 1'b0;
        last_d  = 1'b0;

        if (accept) begin
            // Bit 0 goes straight to the output; the rest wait in the shift register.
            state_d = ST_SHIFT;
            shift_d = in_data >> 1;
            cnt_d   = '0;
            bit_d   = in_data[0];
            start_d = 1'b1;
            valid_d = 1'b1;
        end else if (state_q == ST_SHIFT) begin
            if (at_last) begin
                state_d = ST_IDLE;
                shift_d = '0;
                cnt_d   = '0;
            end else begin
                shift_d = shift_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                bit_d   = shift_q[0];
                valid_d = 1'b1;
                last_d  = (cnt_q + 1'b1) == CNT_LAST;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            bit_q   <= 1'b0;
            start_q <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            start_q <= start_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign ser_bit   = bit_q;
    assign ser_start = start_q;
    assign ser_valid = valid_q;
    assign ser_last  = last_q;

endmodule
